scrub_engine: RTL and testbench

Memory scrubber feeding the bit-flip rate monitor. It periodically walks a parity-protected memory one word at a time and checks the stored even parity of each word. On a mismatch it pulses the scrub-vector bit for that word index. The monitor samples that vector to count bit flips and compute cycles per flip.

---
 rtl/scrub_engine_if.sv | 33 +++
 rtl/scrub_engine.sv | 126 ++++++++++++
 tb/tb_scrub_engine.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scrub_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : scrub_engine_if
// Brief    : Read-only memory port used by the scrubber (request/grant/rvalid).
// Revision : 1.0 - initial release
// ============================================================================
interface scrub_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W:0]   mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/scrub_engine.sv
`default_nettype none
// ============================================================================
// Module   : scrub_engine
// Brief    : Periodic parity scrubber; walks memory word by word and pulses
//            a one-hot error vector bit for each word with bad even parity.
// Revision : 1.0 - initial release
// ============================================================================
module scrub_engine #(
    parameter int NUM_WORDS = 100,
    parameter int DATA_W    = 32,
    parameter int PERIOD    = 1000,
    parameter int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  wire logic                 clk_i,
    input  wire logic                 rstn_i,
    input  wire logic                 en_i,
    input  wire logic                 clr_i,
    scrub_engine_if.master            mem,
    output logic [NUM_WORDS-1:0]      scrub_o,
    output logic                      busy_o,
    output logic                      pass_done_o,
    output logic [15:0]               err_cnt_o
);

    localparam int PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_WAIT = 3'd1;
    localparam logic [2:0] c_S_REQ  = 3'd2;
    localparam logic [2:0] c_S_RESP = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    localparam logic [ADDR_W-1:0]    c_LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [PCNT_W-1:0]    c_LAST_CNT  = PCNT_W'(PERIOD - 1);
    localparam logic [NUM_WORDS-1:0] c_ONE       = NUM_WORDS'(1);
    localparam logic [15:0]          c_CNT_MAX   = 16'hFFFF;

    logic [2:0]           r_state;
    logic [PCNT_W-1:0]    r_period_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic [NUM_WORDS-1:0] r_scrub;
    logic [15:0]          r_err_cnt;

    logic w_rsp;
    logic w_err;

    // Responses are only meaningful while a transaction is outstanding.
    assign w_rsp = (r_state == c_S_RESP) && mem.mem_rvalid_i;
    assign w_err = w_rsp && (^mem.mem_rdata_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= c_S_IDLE;
            r_period_cnt <= '0;
            r_addr       <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (en_i) begin
                        r_period_cnt <= '0;
                        r_state      <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (!en_i) begin
                        r_state <= c_S_IDLE;
                    end else if (r_period_cnt == c_LAST_CNT) begin
                        r_addr  <= '0;
                        r_state <= c_S_REQ;
                    end else begin
                        r_period_cnt <= r_period_cnt + PCNT_W'(1);
                    end
                end
                c_S_REQ: begin
                    // Request is held even if en_i drops; a grant is never abandoned.
                    if (mem.mem_gnt_i) begin
                        r_state <= c_S_RESP;
                    end
                end
                c_S_RESP: begin
                    if (mem.mem_rvalid_i) begin
                        if (r_addr == c_LAST_ADDR) begin
                            r_state <= c_S_DONE;
                        end else if (!en_i) begin
                            r_state <= c_S_IDLE;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= c_S_REQ;
                        end
                    end
                end
                c_S_DONE: begin
                    r_period_cnt <= '0;
                    r_state      <= en_i ? c_S_WAIT : c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_scrub   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_scrub <= w_err ? (c_ONE << r_addr) : '0;
            // Clear takes priority over a coincident error; the pulse still fires.
            if (clr_i) begin
                r_err_cnt <= '0;
            end else if (w_err && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign mem.mem_req_o  = (r_state == c_S_REQ);
    assign mem.mem_addr_o = r_addr;
    assign busy_o         = (r_state == c_S_REQ) || (r_state == c_S_RESP);
    assign pass_done_o    = (r_state == c_S_DONE);
    assign scrub_o        = r_scrub;
    assign err_cnt_o      = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scrub_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_scrub_engine
// Brief    : Directed, table-driven bench for scrub_engine (4 words, PERIOD 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scrub_engine;

    localparam int NW  = 4;
    localparam int DW  = 32;
    localparam int PER = 3;

    // Even-parity words (XOR of all 33 bits is 0) and odd-parity words.
    localparam logic [32:0] c_G0 = 33'h0_0000_0000;
    localparam logic [32:0] c_G1 = 33'h1_0000_0001;
    localparam logic [32:0] c_G2 = 33'h0_0000_0003;
    localparam logic [32:0] c_G3 = 33'h1_8000_0000;
    localparam logic [32:0] c_B0 = 33'h0_0000_0001;
    localparam logic [32:0] c_B1 = 33'h1_0000_0000;
    localparam logic [32:0] c_B2 = 33'h0_FFFF_FFFE;
    localparam logic [32:0] c_B3 = 33'h1_0000_0003;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          en_i;
    logic          clr_i;
    logic [NW-1:0] scrub_o;
    logic          busy_o;
    logic          pass_done_o;
    logic [15:0]   err_cnt_o;

    scrub_engine_if #(.DATA_W(DW), .ADDR_W(2)) mem_if ();

    scrub_engine #(.NUM_WORDS(NW), .DATA_W(DW), .PERIOD(PER)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .mem         (mem_if),
        .scrub_o     (scrub_o),
        .busy_o      (busy_o),
        .pass_done_o (pass_done_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0][32:0] w;
        int               gd;
        int               rd;
        logic [3:0]       exp_or;
        int               exp_pulses;
        logic [15:0]      exp_cnt;
    } vec_t;

    vec_t vecs [6];

    int tests  = 0;
    int failed = 0;

    // Stimulus controls written by the main process, read by the responder.
    logic [32:0] mem_data [4];
    int          gnt_dly  = 0;
    int          rv_dly   = 0;
    bit          stray_en = 1'b0;

    // Observation logs written by the monitor only.
    logic [1:0]  req_log [$];
    logic [3:0]  scrub_log [$];
    int          done_cnt  = 0;
    int          stab_err  = 0;
    int          nonhot    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    function automatic vec_t mk(logic [32:0] w0, logic [32:0] w1, logic [32:0] w2,
                                logic [32:0] w3, int gd, int rd, logic [3:0] eo,
                                int ep, logic [15:0] ec);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.gd = gd; v.rd = rd; v.exp_or = eo; v.exp_pulses = ep; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic load_mem(input logic [32:0] w0, input logic [32:0] w1,
                            input logic [32:0] w2, input logic [32:0] w3);
        mem_data[0] = w0; mem_data[1] = w1; mem_data[2] = w2; mem_data[3] = w3;
    endtask

    function automatic logic [8:0] addrs_since(int q0);
        logic [8:0] r = '0;
        if (req_log.size() - q0 != 4) r[8] = 1'b1;
        else for (int k = 0; k < 4; k++) r[k*2 +: 2] = req_log[q0 + k];
        return r;
    endfunction

    function automatic logic [3:0] scrub_or_since(int s0);
        logic [3:0] r = '0;
        for (int k = s0; k < scrub_log.size(); k++) r |= scrub_log[k];
        return r;
    endfunction

    task automatic wait_done(input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (pass_done_o) begin ok = 1'b1; break; end
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    task automatic wait_req(input logic [1:0] a, input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (mem_if.mem_req_o && mem_if.mem_addr_o == a) begin ok = 1'b1; break; end
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    task automatic count_to_req(output int n);
        n = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (mem_if.mem_req_o) begin n = k; break; end
        end
    endtask

    // Memory responder: configurable grant and read-data latency.
    initial begin : responder
        bit          pending = 1'b0;
        bit          in_req  = 1'b0;
        int          g_cnt   = 0;
        int          rv_cnt  = 0;
        logic [1:0]  lat     = '0;
        mem_if.mem_gnt_i    = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            mem_if.mem_gnt_i    = 1'b0;
            mem_if.mem_rvalid_i = 1'b0;
            if (!rstn_i) begin
                pending = 1'b0;
                in_req  = 1'b0;
            end else if (pending) begin
                if (rv_cnt == 0) begin
                    mem_if.mem_rvalid_i = 1'b1;
                    mem_if.mem_rdata_i  = mem_data[lat];
                    pending = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else begin
                if (stray_en) begin
                    mem_if.mem_rvalid_i = 1'b1;
                    mem_if.mem_rdata_i  = c_B0;
                end
                if (mem_if.mem_req_o) begin
                    if (!in_req) begin
                        in_req = 1'b1;
                        g_cnt  = gnt_dly;
                    end
                    if (g_cnt == 0) begin
                        mem_if.mem_gnt_i = 1'b1;
                        lat     = mem_if.mem_addr_o;
                        pending = 1'b1;
                        rv_cnt  = rv_dly;
                        in_req  = 1'b0;
                    end else begin
                        g_cnt--;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic       prev_req  = 1'b0;
        logic [1:0] prev_addr = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_if.mem_req_o && !prev_req) req_log.push_back(mem_if.mem_addr_o);
            if (mem_if.mem_req_o && prev_req && mem_if.mem_addr_o != prev_addr) stab_err++;
            if (pass_done_o) done_cnt++;
            if (scrub_o != '0) begin
                scrub_log.push_back(scrub_o);
                if (!$onehot(scrub_o)) nonhot++;
            end
            prev_req  = mem_if.mem_req_o;
            prev_addr = mem_if.mem_addr_o;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, q0, s0, d0;

        vecs[0] = mk(c_G0, c_G1, c_G2, c_G3, 0, 0, 4'b0000, 0, 16'd0);
        vecs[1] = mk(c_G0, c_G1, c_B0, c_G3, 0, 0, 4'b0100, 1, 16'd1);
        vecs[2] = mk(c_B1, c_G1, c_G2, c_B2, 3, 5, 4'b1001, 2, 16'd3);
        vecs[3] = mk(c_B0, c_B1, c_B2, c_B3, 1, 0, 4'b1111, 4, 16'd7);
        vecs[4] = mk(c_G2, c_B3, c_G0, c_G1, 0, 2, 4'b0010, 1, 16'd8);
        vecs[5] = mk(c_G3, c_G2, c_G1, c_G0, 3, 5, 4'b0000, 0, 16'd8);

        rstn_i = 1'b0;
        en_i   = 1'b0;
        clr_i  = 1'b0;
        load_mem(c_G0, c_G1, c_G2, c_G3);
        tick();
        tick();
        check("rst_req",   32'(mem_if.mem_req_o),  32'd0);
        check("rst_addr",  32'(mem_if.mem_addr_o), 32'd0);
        check("rst_busy",  32'(busy_o),            32'd0);
        check("rst_done",  32'(pass_done_o),       32'd0);
        check("rst_scrub", 32'(scrub_o),           32'd0);
        check("rst_cnt",   32'(err_cnt_o),         32'd0);

        // Clean first pass, with first-request latency.
        @(negedge clk_i);
        #1;
        en_i   = 1'b1;
        rstn_i = 1'b1;
        count_to_req(n);
        check("first_req_cycle", 32'(n), 32'd4);
        wait_done("p0_done");
        check("p0_addrs", 32'(addrs_since(0)), 32'h0E4);
        check("p0_scrub", 32'(scrub_log.size()), 32'd0);
        check("p0_cnt",   32'(err_cnt_o), 32'd0);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) mem_data[k] = vecs[i].w[k];
            gnt_dly = vecs[i].gd;
            rv_dly  = vecs[i].rd;
            q0 = req_log.size();
            s0 = scrub_log.size();
            d0 = done_cnt;
            wait_done($sformatf("v%0d_done", i));
            check($sformatf("v%0d_addrs", i),  32'(addrs_since(q0)), 32'h0E4);
            check($sformatf("v%0d_or", i),     32'(scrub_or_since(s0)), 32'(vecs[i].exp_or));
            check($sformatf("v%0d_pulses", i), 32'(scrub_log.size() - s0), 32'(vecs[i].exp_pulses));
            check($sformatf("v%0d_cnt", i),    32'(err_cnt_o), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_ndone", i),  32'(done_cnt - d0), 32'd1);
        end
        check("stall_stable", 32'(stab_err), 32'd0);
        gnt_dly = 0;
        rv_dly  = 0;

        // Single error: exact one-cycle pulse timing.
        load_mem(c_G0, c_G1, c_B0, c_G3);
        wait_req(2'd2, "single_req");
        tick();
        check("single_pre",   32'(scrub_o), 32'd0);
        tick();
        check("single_pulse", 32'(scrub_o), 32'b0100);
        check("single_cnt",   32'(err_cnt_o), 32'd9);
        tick();
        check("single_post",  32'(scrub_o), 32'd0);
        wait_done("single_done");

        // Stray rvalids outside RESP are ignored.
        load_mem(c_G0, c_G1, c_G2, c_G3);
        s0 = scrub_log.size();
        stray_en = 1'b1;
        tick();
        tick();
        stray_en = 1'b0;
        wait_done("stray_done");
        check("stray_scrub", 32'(scrub_log.size() - s0), 32'd0);
        check("stray_cnt",   32'(err_cnt_o), 32'd9);

        // Abort in RESP on word 1: response consumed, no pass_done.
        load_mem(c_G0, c_B1, c_G2, c_G3);
        wait_req(2'd1, "abort_req");
        tick();
        check("abort_in_resp", 32'({busy_o, mem_if.mem_req_o}), 32'b10);
        en_i = 1'b0;
        d0 = done_cnt;
        tick();
        check("abort_pulse", 32'(scrub_o), 32'b0010);
        check("abort_idle",  32'(busy_o), 32'd0);
        q0 = req_log.size();
        repeat (10) tick();
        check("abort_noreq",  32'(req_log.size() - q0), 32'd0);
        check("abort_nodone", 32'(done_cnt - d0), 32'd0);
        check("abort_cnt",    32'(err_cnt_o), 32'd10);
        load_mem(c_G0, c_G1, c_G2, c_G3);
        q0 = req_log.size();
        en_i = 1'b1;
        count_to_req(n);
        check("reen_req_cycle", 32'(n), 32'd4);
        check("reen_addr0",     32'(mem_if.mem_addr_o), 32'd0);
        wait_done("reen_done");
        check("reen_addrs", 32'(addrs_since(q0)), 32'h0E4);

        // Saturation near the top of the counter.
        load_mem(c_B0, c_G1, c_B2, c_G3);
        force dut.r_err_cnt = 16'hFFFE;
        tick();
        release dut.r_err_cnt;
        tick();
        check("sat_preload", 32'(err_cnt_o), 32'hFFFE);
        s0 = scrub_log.size();
        wait_done("sat_done");
        check("sat_cnt",    32'(err_cnt_o), 32'hFFFF);
        check("sat_pulses", 32'(scrub_log.size() - s0), 32'd2);

        // Clear coincident with an error: clear wins, pulse still fires.
        load_mem(c_G0, c_G1, c_G2, c_B3);
        wait_req(2'd3, "clr_req");
        tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_wins",  32'(err_cnt_o), 32'd0);
        check("clr_pulse", 32'(scrub_o), 32'b1000);
        wait_done("clr_next_done");
        check("clr_then_count", 32'(err_cnt_o), 32'd1);

        // Asynchronous reset in REQ.
        wait_req(2'd2, "arst_req");
        #1;
        rstn_i = 1'b0;
        #1;
        check("arst_req0",   32'(mem_if.mem_req_o),  32'd0);
        check("arst_addr0",  32'(mem_if.mem_addr_o), 32'd0);
        check("arst_busy0",  32'(busy_o),            32'd0);
        check("arst_cnt0",   32'(err_cnt_o),         32'd0);
        check("arst_scrub0", 32'(scrub_o),           32'd0);
        @(negedge clk_i);
        #1;
        rstn_i = 1'b1;
        q0 = req_log.size();
        count_to_req(n);
        check("arst_req_cycle", 32'(n), 32'd4);
        wait_done("arst_done");
        check("arst_addrs", 32'(addrs_since(q0)), 32'h0E4);

        check("onehot_pulses", 32'(nonhot), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
